ifu_fetch: RTL
==============

Name: ifu_fetch

Overview:
- Instruction fetch unit that sits directly upstream of the datapath/controller pair.
- Holds the PC and computes the next PC from NPC_Sel, Zero and the jump-register operand.
- Fetches each word over a request/acknowledge handshake with an instruction memory of variable latency.
- Presents Instr, PC and PC4 to the core and keeps them stable until the core signals Advance.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset; must be word aligned.

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
NPC_Sel  input  2  next-PC select from the controller: 00 PC+4, 01 beq, 10 j/jal, 11 jr
Zero  input  1  ALU equality flag; used only when NPC_Sel=01
RegA  input  32  rs register value; jr target
Advance  input  1  core has finished the current instruction; PC may update
IMem_Req  output  1  fetch request to instruction memory
IMem_Addr  output  32  fetch address; equals PC
IMem_Ack  input  1  memory returns data this cycle
IMem_RData  input  32  instruction word, valid when IMem_Ack=1
Instr  output  32  current instruction
Instr_Valid  output  1  Instr, PC and PC4 are valid
PC  output  32  address of Instr
PC4  output  32  PC+4, used as the jal link value
Fault  output  1  sticky flag: misaligned jr target

Behaviour:
- Reset is asynchronous. While Reset is high and after it falls:
  - PC=RESET_PC, Instr=0, state=FETCH, Fault=0.
  - IMem_Req is forced to 0 while Reset is high.
  - Instr_Valid=0.
- FSM has three states: FETCH, VALID, HALT.
- FETCH:
  - IMem_Req=1 and IMem_Addr=PC, both held stable until acknowledged.
  - On a rising edge with IMem_Ack=1: Instr<=IMem_RData, go to VALID.
  - IMem_Ack in any other state is ignored.
- VALID:
  - Instr_Valid=1, IMem_Req=0.
  - On an edge with Advance=1: PC<=NPC, go to FETCH. Instr keeps its old value but Instr_Valid drops.
  - Advance in FETCH or HALT is ignored.
- NPC computation; all arithmetic is modulo 2^32, so 32'hFFFF_FFFC+4 wraps to 0:
  - 00: PC+4.
  - 01: if Zero, PC+4+(sign_extend(Instr[15:0])<<2); otherwise PC+4.
  - 10: {PC4[31:28], Instr[25:0], 2'b00}.
  - 11: RegA.
- Misaligned jr: if NPC_Sel=11 and RegA[1:0]!=0 when Advance is taken, PC is left unchanged, Fault<=1 and the FSM goes to HALT. HALT is exited only by Reset.
- PC4 is always PC+4, computed combinationally.
- Latency: Advance at edge n puts the FSM in FETCH during cycle n+1. An Ack in that same cycle gives Instr_Valid=1 in cycle n+2. The minimum is therefore 2 cycles per instruction.
- Reset during FETCH aborts the request. Any Ack that arrives after reset for the aborted request is ignored until the new FETCH state is entered. The memory must drop a pending response when Req falls.

Decomposition:
- Shared package ifu_pkg:
  - NPC_Sel encodings: NPC_PC4, NPC_BEQ, NPC_J, NPC_JR.
  - FSM state encoding.
  - Default RESET_PC constant.
- Sub-module npc_calc (purely combinational): inputs PC, Instr[25:0], NPC_Sel, Zero, RegA; outputs NPC and Misaligned.

Test Plan:
- Reset released, Ack 3 cycles later with RData=32'h3C01_1234 → IMem_Req=1 and IMem_Addr=32'h3000 held stable for 3 cycles; then Instr=32'h3C01_1234, Instr_Valid=1, PC4=32'h3004.
- At PC=32'h3000, NPC_Sel=01, Zero=1, Instr[15:0]=16'hFFFF, Advance → next IMem_Addr=32'h3000. Repeat with Zero=0 → 32'h3004.
- At PC=32'h3004, NPC_Sel=10, Instr[25:0]=26'h0000C10, Advance → IMem_Addr=32'h0000_3040.
- NPC_Sel=11, RegA=32'h0000_3012, Advance → Fault=1, IMem_Req stays 0, PC unchanged; Fault clears only after Reset.
- Reset asserted mid-FETCH at PC=32'h3040, then a stale Ack arrives after release → PC=32'h3000 and the stale data is ignored until FETCH re-issues; the first data captured is for address 32'h3000.
- Advance pulses while in FETCH, plus a spurious Ack while in VALID → no change to PC or Instr.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared encodings for the instruction fetch unit: next-PC selects, FSM states
// and the default reset vector.
package ifu_pkg;

    typedef enum logic [1:0] {
        NPC_PC4 = 2'b00,
        NPC_BEQ = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_sel_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_VALID = 2'b01,
        ST_HALT  = 2'b10
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/ifu_fetch_npc_calc.sv
// Combinational next-PC: sequential, conditional branch, absolute jump or
// register jump, plus a flag for a jr target that is not word aligned.
module npc_calc
    import ifu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] instr,
    input  logic [1:0]  npc_sel,
    input  logic        zero,
    input  logic [31:0] rega,
    output logic [31:0] npc,
    output logic        misaligned
);

    logic [31:0] pc4;
    logic [31:0] br_off;

    always_comb begin
        pc4        = pc + 32'd4;
        br_off     = {{14{instr[15]}}, instr[15:0], 2'b00};
        misaligned = 1'b0;
        case (npc_sel_e'(npc_sel))
            NPC_BEQ: npc = zero ? (pc4 + br_off) : pc4;
            NPC_J:   npc = {pc4[31:28], instr, 2'b00};
            NPC_JR: begin
                npc        = rega;
                misaligned = (rega[1:0] != 2'b00);
            end
            default: npc = pc4;
        endcase
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word per request/ack
// handshake and holds it for the core until Advance.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  NPC_Sel,
    input  logic        Zero,
    input  logic [31:0] RegA,
    input  logic        Advance,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Ack,
    input  logic [31:0] IMem_RData,
    output logic [31:0] Instr,
    output logic        Instr_Valid,
    output logic [31:0] PC,
    output logic [31:0] PC4,
    output logic        Fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         fault_q, fault_d;

    logic [31:0]  npc;
    logic         npc_misaligned;

    npc_calc u_npc_calc (
        .pc         (pc_q),
        .instr      (instr_q[25:0]),
        .npc_sel    (NPC_Sel),
        .zero       (Zero),
        .rega       (RegA),
        .npc        (npc),
        .misaligned (npc_misaligned)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        fault_d = fault_q;
        case (state_q)
            ST_FETCH: begin
                if (IMem_Ack) begin
                    instr_d = IMem_RData;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (Advance) begin
                    // A bad jr target freezes the PC so the offending instruction stays visible.
                    if (npc_misaligned) begin
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = npc;
                        state_d = ST_FETCH;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end

    // Reset gates the request so an in-flight fetch is dropped immediately.
    assign IMem_Req    = (state_q == ST_FETCH) && !Reset;
    assign IMem_Addr   = pc_q;
    assign Instr       = instr_q;
    assign Instr_Valid = (state_q == ST_VALID);
    assign PC          = pc_q;
    assign PC4         = pc_q + 32'd4;
    assign Fault       = fault_q;

endmodule
